// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-rate divider, h/v counters, registered pixel stream and delayed syncs.
// Optional VGA_SYNC_FRAME_CNT_EN adds a 16-bit wrapping frame counter output.
module vga_sync_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_pix_valid,
  output logic [9:0]  o_col,
  output logic [9:0]  o_row,
  output logic        o_pix_tick,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [15:0] o_frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
    end
    if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_div
      $error("vga_sync_gen: CLK_DIV must be 1..8");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_dly
      $error("vga_sync_gen: SYNC_DELAY must be 0..4");
    end
  endgenerate

  localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [2:0] div_q, div_d;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic       tick, act, hs_raw, vs_raw, fs_raw;
  logic [SYNC_DELAY:0] hs_pipe_q, vs_pipe_q;

  always_comb begin
    tick   = (div_q == DIV_LAST);
    div_d  = tick ? 3'd0 : div_q + 3'd1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = 10'd0;
        vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
    act    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    hs_raw = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    vs_raw = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    fs_raw = (div_q == 3'd0) && (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
  end

  // Outputs register the current counter state, so they trail the counters by one clk.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q         <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      o_pix_valid   <= 1'b0;
      o_col         <= '0;
      o_row         <= '0;
      o_pix_tick    <= 1'b0;
      o_frame_start <= 1'b0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
    end else begin
      div_q         <= div_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      o_pix_valid   <= act;
      o_col         <= hcnt_q;
      o_row         <= vcnt_q;
      o_pix_tick    <= tick;
      o_frame_start <= fs_raw;
      hs_pipe_q[0]  <= hs_raw;
      vs_pipe_q[0]  <= vs_raw;
      for (int i = 1; i <= SYNC_DELAY; i++) begin
        hs_pipe_q[i] <= hs_pipe_q[i-1];
        vs_pipe_q[i] <= vs_pipe_q[i-1];
      end
    end
  end

  assign o_hsync = hs_pipe_q[SYNC_DELAY];
  assign o_vsync = vs_pipe_q[SYNC_DELAY];

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] fcnt_q;

  always_ff @(posedge clk) begin
    if (!rst)        fcnt_q <= '0;
    else if (fs_raw) fcnt_q <= fcnt_q + 16'd1;
  end

  assign o_frame_cnt = fcnt_q;
`endif

endmodule
